// File: rtl/mem_cmd_sched.sv
// Memory command scheduler: arbitrates read/write/refresh/scrub into a one-entry command register.
// Define MEM_CMD_SCHED_SCRUB_EN to compile the scrub requester into arbitration.

package cmd_defs_pkg;
    localparam logic [2:0] CMD_NOP     = 3'd0;
    localparam logic [2:0] CMD_READ    = 3'd1;
    localparam logic [2:0] CMD_WRITE   = 3'd2;
    localparam logic [2:0] CMD_SCRUB   = 3'd3;
    localparam logic [2:0] CMD_REFRESH = 3'd4;
endpackage

module mem_cmd_sched
    import cmd_defs_pkg::*;
#(
    parameter int REF_INTERVAL = 64,
    parameter int REF_URGENT   = 4,
    parameter int WR_STARVE    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_valid,
    input  logic [31:0] rd_addr,
    output logic        rd_ready,
    input  logic        wr_valid,
    input  logic [31:0] wr_addr,
    output logic        wr_ready,
    input  logic        scrub_valid,
    input  logic [31:0] scrub_addr,
    output logic        scrub_ready,
    input  logic        fsm_ready,
    output logic        cmd_valid,
    output logic [2:0]  cmd_type,
    output logic [31:0] cmd_addr,
    output logic [3:0]  ref_pending,
    output logic        ref_overflow
);

    localparam logic [15:0] REF_RELOAD = 16'(REF_INTERVAL - 1);
    localparam logic [3:0]  URGENT_LVL = 4'(REF_URGENT);
    localparam logic [7:0]  STARVE_LVL = 8'(WR_STARVE);
    localparam logic [3:0]  PEND_MAX   = 4'd8;

    logic        cmd_valid_q, cmd_valid_d;
    logic [2:0]  cmd_type_q, cmd_type_d;
    logic [31:0] cmd_addr_q, cmd_addr_d;
    logic [3:0]  ref_pending_q, ref_pending_d;
    logic        ref_overflow_q, ref_overflow_d;
    logic [7:0]  starve_cnt_q, starve_cnt_d;
    logic [15:0] ref_timer_q, ref_timer_d;

    logic slot_free, ref_tick, scrub_req;
    logic gnt_rd, gnt_wr, gnt_ref, gnt_scrub;

`ifdef MEM_CMD_SCHED_SCRUB_EN
    assign scrub_req = scrub_valid;
`else
    logic unused_scrub;
    assign unused_scrub = ^{scrub_valid, scrub_addr};
    assign scrub_req    = 1'b0;
`endif

    always_comb begin
        slot_free = !cmd_valid_q || fsm_ready;
        ref_tick  = (ref_timer_q == 16'd0);
        gnt_rd    = 1'b0;
        gnt_wr    = 1'b0;
        gnt_ref   = 1'b0;
        gnt_scrub = 1'b0;
        // Readies are combinational, so they are held low while reset is active.
        if (slot_free && !rst) begin
            if (ref_pending_q >= URGENT_LVL)                   gnt_ref   = 1'b1;
            else if (wr_valid && starve_cnt_q == STARVE_LVL)   gnt_wr    = 1'b1;
            else if (rd_valid)                                 gnt_rd    = 1'b1;
            else if (wr_valid)                                 gnt_wr    = 1'b1;
            else if (ref_pending_q != 4'd0)                    gnt_ref   = 1'b1;
            else if (scrub_req)                                gnt_scrub = 1'b1;
        end
    end

    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_type_d  = cmd_type_q;
        cmd_addr_d  = cmd_addr_q;
        if (slot_free) begin
            cmd_valid_d = gnt_rd || gnt_wr || gnt_ref || gnt_scrub;
            cmd_type_d  = CMD_NOP;
            cmd_addr_d  = 32'd0;
            if (gnt_ref) begin
                cmd_type_d = CMD_REFRESH;
            end else if (gnt_wr) begin
                cmd_type_d = CMD_WRITE;
                cmd_addr_d = wr_addr;
            end else if (gnt_rd) begin
                cmd_type_d = CMD_READ;
                cmd_addr_d = rd_addr;
            end else if (gnt_scrub) begin
                cmd_type_d = CMD_SCRUB;
                cmd_addr_d = scrub_addr;
            end
        end

        starve_cnt_d = starve_cnt_q;
        if (gnt_wr)
            starve_cnt_d = 8'd0;
        else if (gnt_rd && wr_valid && starve_cnt_q != STARVE_LVL)
            starve_cnt_d = starve_cnt_q + 8'd1;

        ref_timer_d = ref_tick ? REF_RELOAD : ref_timer_q - 16'd1;

        // A tick coinciding with a refresh load cancels out; only an unabsorbed tick at 8 is lost.
        ref_pending_d  = ref_pending_q;
        ref_overflow_d = ref_overflow_q;
        if (ref_tick && !gnt_ref) begin
            if (ref_pending_q == PEND_MAX)
                ref_overflow_d = 1'b1;
            else
                ref_pending_d = ref_pending_q + 4'd1;
        end else if (!ref_tick && gnt_ref) begin
            ref_pending_d = ref_pending_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid_q    <= 1'b0;
            cmd_type_q     <= CMD_NOP;
            cmd_addr_q     <= 32'd0;
            ref_pending_q  <= 4'd0;
            ref_overflow_q <= 1'b0;
            starve_cnt_q   <= 8'd0;
            ref_timer_q    <= REF_RELOAD;
        end else begin
            cmd_valid_q    <= cmd_valid_d;
            cmd_type_q     <= cmd_type_d;
            cmd_addr_q     <= cmd_addr_d;
            ref_pending_q  <= ref_pending_d;
            ref_overflow_q <= ref_overflow_d;
            starve_cnt_q   <= starve_cnt_d;
            ref_timer_q    <= ref_timer_d;
        end
    end

    assign rd_ready     = gnt_rd;
    assign wr_ready     = gnt_wr;
    assign scrub_ready  = gnt_scrub;
    assign cmd_valid    = cmd_valid_q;
    assign cmd_type     = cmd_type_q;
    assign cmd_addr     = cmd_addr_q;
    assign ref_pending  = ref_pending_q;
    assign ref_overflow = ref_overflow_q;

endmodule

// File: tb/tb_mem_cmd_sched.sv
// Directed bench for mem_cmd_sched with REF_INTERVAL=16, REF_URGENT=2, WR_STARVE=3.
// Scrub expectations follow MEM_CMD_SCHED_SCRUB_EN when the bench is built.

module tb_mem_cmd_sched;
    import cmd_defs_pkg::*;

    logic        clk;
    logic        rst;
    logic        rd_valid, wr_valid, scrub_valid, fsm_ready;
    logic [31:0] rd_addr, wr_addr, scrub_addr;
    logic        rd_ready, wr_ready, scrub_ready;
    logic        cmd_valid;
    logic [2:0]  cmd_type;
    logic [31:0] cmd_addr;
    logic [3:0]  ref_pending;
    logic        ref_overflow;

    int n_assert = 0;
    int n_fail   = 0;

    mem_cmd_sched #(
        .REF_INTERVAL(16),
        .REF_URGENT  (2),
        .WR_STARVE   (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_valid    (rd_valid),
        .rd_addr     (rd_addr),
        .rd_ready    (rd_ready),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_ready    (wr_ready),
        .scrub_valid (scrub_valid),
        .scrub_addr  (scrub_addr),
        .scrub_ready (scrub_ready),
        .fsm_ready   (fsm_ready),
        .cmd_valid   (cmd_valid),
        .cmd_type    (cmd_type),
        .cmd_addr    (cmd_addr),
        .ref_pending (ref_pending),
        .ref_overflow(ref_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        rd_valid    = 1'b0;
        wr_valid    = 1'b0;
        scrub_valid = 1'b0;
        rd_addr     = 32'd0;
        wr_addr     = 32'd0;
        scrub_addr  = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        fsm_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_cmd(input string tag, input logic v, input logic [2:0] t, input logic [31:0] a);
        chk({tag, ".valid"}, 32'(cmd_valid), 32'(v));
        chk({tag, ".type"},  32'(cmd_type),  32'(t));
        chk({tag, ".addr"},  cmd_addr,       a);
    endtask

    bit exp_w [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rst = 1'b1;
        idle_inputs();
        fsm_ready = 1'b1;
        step();
        rd_valid = 1'b1;
        rd_addr  = 32'h55;
        settle();
        chk("rst_rd_ready_low", 32'(rd_ready), 32'd0);
        step();
        rst = 1'b0;
        rd_valid = 1'b0;
        settle();
        chk_cmd("reset_cmd", 1'b0, CMD_NOP, 32'd0);
        chk("reset_pending",  32'(ref_pending),  32'd0);
        chk("reset_overflow", 32'(ref_overflow), 32'd0);
        chk("reset_readies",  32'({rd_ready, wr_ready, scrub_ready}), 32'd0);

        // single read
        do_reset();
        rd_valid = 1'b1;
        rd_addr  = 32'h1234;
        settle();
        chk("rd1_rd_ready", 32'(rd_ready), 32'd1);
        chk("rd1_wr_ready", 32'(wr_ready), 32'd0);
        step();
        chk_cmd("rd1_cmd", 1'b1, CMD_READ, 32'h1234);
        rd_valid = 1'b0;
        settle();
        chk("rd1_ready_drop", 32'(rd_ready), 32'd0);
        step();
        chk_cmd("rd1_empty", 1'b0, CMD_NOP, 32'd0);

        // backpressure hold, then zero-bubble reload
        do_reset();
        wr_valid = 1'b1;
        wr_addr  = 32'hA0;
        settle();
        chk("bp_wr_ready", 32'(wr_ready), 32'd1);
        step();
        wr_valid  = 1'b0;
        fsm_ready = 1'b0;
        rd_valid  = 1'b1;
        rd_addr   = 32'hB0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("bp_rd_blocked", 32'(rd_ready), 32'd0);
            chk_cmd("bp_hold", 1'b1, CMD_WRITE, 32'hA0);
            step();
        end
        fsm_ready = 1'b1;
        settle();
        chk("bp_rd_ready", 32'(rd_ready), 32'd1);
        step();
        rd_valid = 1'b0;
        chk_cmd("bp_next", 1'b1, CMD_READ, 32'hB0);

        // write starvation pattern R,R,R,W,R,R,R,W
        do_reset();
        rd_valid = 1'b1;
        rd_addr  = 32'h100;
        wr_valid = 1'b1;
        wr_addr  = 32'h200;
        for (int i = 0; i < 8; i++) begin
            settle();
            chk("starve_rd_ready", 32'(rd_ready), 32'(!exp_w[i]));
            chk("starve_wr_ready", 32'(wr_ready), 32'(exp_w[i]));
            step();
            chk("starve_cmd_type", 32'(cmd_type), 32'(exp_w[i] ? CMD_WRITE : CMD_READ));
        end
        idle_inputs();

        // refresh accrual and urgent refresh ahead of a read
        do_reset();
        rd_valid = 1'b1;
        rd_addr  = 32'h10;
        step();
        rd_valid  = 1'b0;
        fsm_ready = 1'b0;
        for (int k = 2; k <= 32; k++) begin
            step();
            if (k == 15) chk("ref_pend_e15", 32'(ref_pending), 32'd0);
            if (k == 16) chk("ref_pend_e16", 32'(ref_pending), 32'd1);
        end
        chk("ref_pend_e32", 32'(ref_pending), 32'd2);
        chk_cmd("ref_held", 1'b1, CMD_READ, 32'h10);
        rd_valid  = 1'b1;
        rd_addr   = 32'h20;
        fsm_ready = 1'b1;
        settle();
        chk("ref_rd_blocked", 32'(rd_ready), 32'd0);
        step();
        chk_cmd("ref_cmd", 1'b1, CMD_REFRESH, 32'd0);
        chk("ref_pend_dec", 32'(ref_pending), 32'd1);
        settle();
        chk("ref_rd_next", 32'(rd_ready), 32'd1);
        step();
        rd_valid = 1'b0;
        chk_cmd("ref_rd_cmd", 1'b1, CMD_READ, 32'h20);
        chk("ref_pend_keep", 32'(ref_pending), 32'd1);

        // saturation, overflow, and mid-handshake reset
        do_reset();
        rd_valid = 1'b1;
        rd_addr  = 32'h30;
        step();
        rd_valid  = 1'b0;
        fsm_ready = 1'b0;
        for (int k = 2; k <= 144; k++) begin
            step();
            if (k == 128) chk("sat_pend_e128", 32'(ref_pending), 32'd8);
            if (k == 143) chk("sat_ovf_e143", 32'(ref_overflow), 32'd0);
        end
        chk("sat_pend_e144", 32'(ref_pending), 32'd8);
        chk("sat_ovf_e144", 32'(ref_overflow), 32'd1);
        chk_cmd("sat_held", 1'b1, CMD_READ, 32'h30);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("clr_pending",  32'(ref_pending),  32'd0);
        chk("clr_overflow", 32'(ref_overflow), 32'd0);
        chk("clr_cmd_valid", 32'(cmd_valid), 32'd0);
        fsm_ready = 1'b1;
        step();
        chk_cmd("clr_no_reissue", 1'b0, CMD_NOP, 32'd0);

        // scrub requester
        do_reset();
        scrub_valid = 1'b1;
        scrub_addr  = 32'h5C;
        settle();
`ifdef MEM_CMD_SCHED_SCRUB_EN
        chk("scrub_ready", 32'(scrub_ready), 32'd1);
        step();
        scrub_valid = 1'b0;
        chk_cmd("scrub_cmd", 1'b1, CMD_SCRUB, 32'h5C);
`else
        chk("scrub_ready_off", 32'(scrub_ready), 32'd0);
        step();
        chk_cmd("scrub_cmd_off", 1'b0, CMD_NOP, 32'd0);
        step();
        chk("scrub_ready_off2", 32'(scrub_ready), 32'd0);
        scrub_valid = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
